// File: rtl/mem_io_bus_pkg.sv
// mem_io_pkg: shared definitions for the data-side memory/I/O unit.
//   - address map constants (RAM top, memory-mapped register addresses)
//   - LFSR feedback tap mask and next-state helper
//   - register-select enum and address decoder used by the read mux and
//     the write-enable logic, so reads and writes share one decode
package mem_io_pkg;

  localparam logic [7:0] RAM_TOP        = 8'hEF;
  localparam logic [7:0] ADDR_BTN_LEVEL = 8'hF0;
  localparam logic [7:0] ADDR_BTN_EVENT = 8'hF1;
  localparam logic [7:0] ADDR_SW        = 8'hF2;
  localparam logic [7:0] ADDR_RAND      = 8'hF3;
  localparam logic [7:0] ADDR_TIMER     = 8'hF4;
  localparam logic [7:0] ADDR_LED       = 8'hF5;

  // Feedback taps q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    SEL_RAM       = 3'd0,
    SEL_BTN_LEVEL = 3'd1,
    SEL_BTN_EVENT = 3'd2,
    SEL_SW        = 3'd3,
    SEL_RAND      = 3'd4,
    SEL_TIMER     = 3'd5,
    SEL_LED       = 3'd6,
    SEL_NONE      = 3'd7
  } reg_sel_e;

  // Map a byte address onto exactly one target; unmapped I/O is SEL_NONE
  function automatic reg_sel_e addr_decode(input logic [7:0] addr);
    reg_sel_e sel;
    if (addr <= RAM_TOP) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_BTN_LEVEL: sel = SEL_BTN_LEVEL;
        ADDR_BTN_EVENT: sel = SEL_BTN_EVENT;
        ADDR_SW:        sel = SEL_SW;
        ADDR_RAND:      sel = SEL_RAND;
        ADDR_TIMER:     sel = SEL_TIMER;
        ADDR_LED:       sel = SEL_LED;
        default:        sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  // Fibonacci shift: new bit 0 is the XOR of the tapped bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_io_bus_if.sv
// mem_io_bus_if: data-side bus between the CPU core and the memory/I/O unit.
//   ADDR  : byte address (core ALU result)
//   WDATA : store data (core register B)
//   MW    : write strobe, commits at the next rising edge
//   RDATA : combinational read data returned to the core
// Modports: master (core side), slave (memory/I/O side).
interface mem_io_bus_if;
  logic [7:0] ADDR;
  logic [7:0] WDATA;
  logic       MW;
  logic [7:0] RDATA;

  modport master (output ADDR, output WDATA, output MW, input RDATA);
  modport slave  (input ADDR, input WDATA, input MW, output RDATA);
endinterface

// File: rtl/mem_io_bus_btn_debounce.sv
// btn_debounce: one push-button input channel.
//   CLK, RESET : clock, synchronous active-high reset
//   btn_raw    : raw asynchronous button
//   level      : debounced level (registered)
//   rise       : high in the cycle whose edge moves level 0->1
// The raw input passes a 2-flop synchronizer; the level only follows the
// synchronized value after it has differed from the level for
// DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: synchronizer shift and stability counter
  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      // Any return to the accepted level discards the partial count
      level_d = level_q;
      cnt_d   = {CW{1'b0}};
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  // Announced one cycle early so the event flag sets at the same edge
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mem_io_bus.sv
// mem_io_bus: data-side memory and I/O unit behind the CPU core.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave side of mem_io_bus_if (ADDR, WDATA, MW in; RDATA out)
//   BTN[4:0]   : raw push buttons (debounced, rising edges latched)
//   SW[7:0]    : raw slide switches (2-flop synchronized)
//   LED[7:0]   : LED register output
// Map: 0x00-0xEF scratch RAM (async read, not reset), 0xF0 BTN_LEVEL,
// 0xF1 BTN_EVENT (W1C), 0xF2 SW, 0xF3 RAND (LFSR), 0xF4 TIMER, 0xF5 LED,
// 0xF6-0xFF read zero. RDATA is combinational so the core sees load data
// in the same cycle; a write returns the old value until after the edge.
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         TICK_CYCLES     = 1000000,
  parameter logic [7:0] LFSR_SEED       = 8'h01
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_io_bus_if.slave       bus,
  input  logic [4:0]        BTN,
  input  logic [7:0]        SW,
  output logic [7:0]        LED
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [7:0]    ram_q [0:239];
  logic [7:0]    led_q, led_d;
  logic [4:0]    event_q, event_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sw_meta_q, sw_meta_d;
  logic [7:0]    sw_sync_q, sw_sync_d;

  logic [4:0]    btn_level;
  logic [4:0]    btn_rise;
  reg_sel_e      sel;
  logic          ram_we;
  logic [4:0]    event_clr;
  logic [7:0]    rdata;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .CLK    (CLK),
      .RESET  (RESET),
      .btn_raw(BTN[i]),
      .level  (btn_level[i]),
      .rise   (btn_rise[i])
    );
  end

  // Decode, register next-state and write enables
  always_comb begin
    sel       = addr_decode(bus.ADDR);
    ram_we    = bus.MW && (sel == SEL_RAM);
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;

    if (bus.MW && (sel == SEL_LED)) begin
      led_d = bus.WDATA;
    end else begin
      led_d = led_q;
    end

    if (bus.MW && (sel == SEL_BTN_EVENT)) begin
      event_clr = bus.WDATA[4:0];
    end else begin
      event_clr = 5'b00000;
    end
    // OR-ing the new rises after the clear lets a set win over a clear
    event_d = (event_q & ~event_clr) | btn_rise;

    if (bus.MW && (sel == SEL_RAND)) begin
      // Zero would lock the LFSR, so it reloads the seed instead
      if (bus.WDATA == 8'h00) begin
        lfsr_d = LFSR_SEED;
      end else begin
        lfsr_d = bus.WDATA;
      end
    end else begin
      lfsr_d = lfsr_next(lfsr_q);
    end

    if (bus.MW && (sel == SEL_TIMER)) begin
      timer_d = bus.WDATA;
      presc_d = {PW{1'b0}};
    end else if (presc_q == PRESC_LAST) begin
      presc_d = {PW{1'b0}};
      if (timer_q == 8'hFF) begin
        timer_d = timer_q;
      end else begin
        timer_d = timer_q + 8'h01;
      end
    end else begin
      presc_d = presc_q + PW'(1);
      timer_d = timer_q;
    end
  end

  // Combinational read mux
  always_comb begin
    case (sel)
      SEL_RAM:       rdata = ram_q[bus.ADDR];
      SEL_BTN_LEVEL: rdata = {3'b000, btn_level};
      SEL_BTN_EVENT: rdata = {3'b000, event_q};
      SEL_SW:        rdata = sw_sync_q;
      SEL_RAND:      rdata = lfsr_q;
      SEL_TIMER:     rdata = timer_q;
      SEL_LED:       rdata = led_q;
      default:       rdata = 8'h00;
    endcase
  end

  assign bus.RDATA = rdata;
  assign LED       = led_q;

  // Scratch RAM write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_q[bus.ADDR] <= bus.WDATA;
    end
  end

  // I/O register state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q     <= 8'h00;
      event_q   <= 5'b00000;
      lfsr_q    <= LFSR_SEED;
      timer_q   <= 8'h00;
      presc_q   <= {PW{1'b0}};
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      led_q     <= led_d;
      event_q   <= event_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

endmodule
